// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, branch redirect
// and the valid/ready instruction handoff to decode.
//   master : the fetch stage (drives imem requests and the decode-side payload)
//   slave  : the environment (instruction memory, branch unit, decode)
interface inst_fetch_if #(
    parameter int unsigned XLEN = 64
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic [6:0]      if_opcode;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output if_valid, if_instr, if_pc, if_opcode,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  if_valid, if_instr, if_pc, if_opcode,
        output if_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues word-aligned requests to
// instruction memory, buffers in-order responses in a small shift queue and
// hands {instr, pc, opcode} to decode over valid/ready. A redirect flushes the
// queue and turns every in-flight request into a stale one that is dropped.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : inst_fetch_if.master (imem req/rsp, redirect, decode handoff)
module inst_fetch #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     FQ_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_fetch_if.master bus
);

    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
    localparam int unsigned SW = CW + 2;
    localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fq_entry_t;

    fq_entry_t         q_q   [FQ_DEPTH];
    fq_entry_t         q_d   [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] vld_q, vld_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     out_q, out_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
    logic              run_q;

    logic [SW-1:0]     occ_c;
    logic              req_valid_c;
    logic              fire_c;
    logic              pop_c;
    logic              push_c;
    logic [CW-1:0]     wr_idx_c;
    logic [XLEN-1:0]   redir_pc_c;
    logic              unused_redir_lsb;

    assign unused_redir_lsb = ^bus.redirect_pc[1:0];
    assign redir_pc_c       = {bus.redirect_pc[XLEN-1:2], 2'b00};

    // Every live request owns a queue slot; stale ones still occupy memory.
    assign occ_c       = SW'(out_q) + SW'(drop_q) + SW'(cnt_q);
    assign req_valid_c = run_q && !bus.redirect_valid && (occ_c < SW'(FQ_DEPTH));
    assign fire_c      = req_valid_c && bus.imem_req_ready;
    assign pop_c       = vld_q[0] && bus.if_ready;
    assign push_c      = bus.imem_rsp_valid && (drop_q == '0) && !bus.redirect_valid;

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_req_addr  = pc_q;

    // Head entry is always slot 0; empty slots are held at zero.
    assign bus.if_valid  = vld_q[0];
    assign bus.if_instr  = q_q[0].instr;
    assign bus.if_pc     = q_q[0].pc;
    assign bus.if_opcode = q_q[0].instr[6:0];

    // Queue next state: shift on pop, write behind the surviving entries.
    always_comb begin : queue_next
        q_d      = q_q;
        vld_d    = vld_q;
        wr_idx_c = cnt_q - CW'(pop_c);
        cnt_d    = cnt_q + CW'(push_c) - CW'(pop_c);
        if (pop_c) begin
            for (int i = 0; i < int'(FQ_DEPTH) - 1; i++) begin
                q_d[i]   = q_q[i+1];
                vld_d[i] = vld_q[i+1];
            end
            q_d[FQ_DEPTH-1]   = '0;
            vld_d[FQ_DEPTH-1] = 1'b0;
        end
        if (push_c) begin
            for (int i = 0; i < int'(FQ_DEPTH); i++) begin
                if (CW'(i) == wr_idx_c) begin
                    q_d[i].instr = bus.imem_rsp_data;
                    q_d[i].pc    = rsp_pc_q;
                    vld_d[i]     = 1'b1;
                end
            end
        end
        if (bus.redirect_valid) begin
            for (int i = 0; i < int'(FQ_DEPTH); i++) begin
                q_d[i] = '0;
            end
            vld_d = '0;
            cnt_d = '0;
        end
    end

    // PC, response-PC tracker and live/stale request accounting.
    always_comb begin : ctrl_next
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        out_d    = out_q;
        drop_d   = drop_q;
        if (bus.redirect_valid) begin
            pc_d     = redir_pc_c;
            rsp_pc_d = redir_pc_c;
            drop_d   = drop_q + out_q - CW'(bus.imem_rsp_valid);
            out_d    = '0;
        end else begin
            if (fire_c) begin
                pc_d = pc_q + INSN_BYTES;
            end
            if (bus.imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push_c) begin
                rsp_pc_d = rsp_pc_q + INSN_BYTES;
            end
            out_d = out_q + CW'(fire_c) - CW'(push_c);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FQ_DEPTH); i++) begin
                q_q[i] <= '0;
            end
            vld_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            drop_q   <= '0;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            run_q    <= 1'b0;
        end else begin
            q_q      <= q_d;
            vld_q    <= vld_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            run_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a latency-programmable in-order imem model, a decode
// monitor that checks every handshake against a queue of expected PCs, and one
// task per scenario.
module tb_inst_fetch;

    localparam int unsigned XLEN = 64;

    logic clk;
    logic rst_n;

    inst_fetch_if #(.XLEN(XLEN)) bus ();

    inst_fetch #(
        .XLEN    (XLEN),
        .RESET_PC('0),
        .FQ_DEPTH(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] exp_q[$];

    typedef struct {
        logic [XLEN-1:0] addr;
        int              due;
    } pend_t;

    pend_t           pend[$];
    int              cyc = 0;
    int              lat = 1;
    int              fire_cnt = 0;
    logic            fire_s = 1'b0;
    logic [XLEN-1:0] addr_s = '0;

    function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
        return {a[26:2] ^ 25'h0A5A5A5, a[5:2], 3'b011};
    endfunction

    // imem model: requests sampled mid-cycle, responses driven after the edge.
    always @(negedge clk) begin
        fire_s = rst_n && bus.imem_req_valid && bus.imem_req_ready;
        addr_s = bus.imem_req_addr;
        if (fire_s) fire_cnt++;
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            pend.delete();
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end else begin
            if (fire_s) pend.push_back('{addr: addr_s, due: cyc + lat - 1});
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
            end
        end
    end

    // Decode-side scoreboard.
    always @(negedge clk) begin
        logic [XLEN-1:0] e;
        logic [31:0]     w;
        if (rst_n && bus.if_valid && bus.if_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_delivery: got pc %h instr %h, expected none", bus.if_pc, bus.if_instr);
            end else begin
                e = exp_q.pop_front();
                w = mem_word(e);
                if (bus.if_pc !== e || bus.if_instr !== w || bus.if_opcode !== w[6:0]) begin
                    errors++;
                    $display("FAIL delivery: got pc %h instr %h op %h, expected pc %h instr %h op %h",
                             bus.if_pc, bus.if_instr, bus.if_opcode, e, w, w[6:0]);
                end
            end
        end
    end

    task automatic run_fires(input int n);
        int target;
        bit done;
        target = fire_cnt + n;
        done = 1'b0;
        bus.imem_req_ready = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clk); #1;
            if (fire_cnt >= target) done = 1'b1;
        end
        bus.imem_req_ready = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL fire_timeout: got %0d fires, expected %0d", fire_cnt, target);
        end
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !bus.if_valid && pend.size() == 0 && !bus.imem_rsp_valid) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending deliveries, expected 0", name, exp_q.size());
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.if_valid !== 1'b0 || bus.if_instr !== '0 ||
            bus.if_pc !== '0 || bus.if_opcode !== '0) begin
            errors++;
            $display("FAIL %s: got req_valid %b if_valid %b instr %h pc %h op %h, expected all 0",
                     name, bus.imem_req_valid, bus.if_valid, bus.if_instr, bus.if_pc, bus.if_opcode);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.if_ready       = 1'b0;
        lat = 1;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset_outputs");
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h0) begin
            errors++;
            $display("FAIL first_req: got valid %b addr %h, expected 1 0", bus.imem_req_valid, bus.imem_req_addr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) exp_q.push_back(64'(i * 4));
        bus.if_ready = 1'b1;
        run_fires(4);
        drain("stream");
    endtask

    task automatic test_decode_stall();
        int base;
        bus.if_ready = 1'b0;
        base = fire_cnt;
        bus.imem_req_ready = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (fire_cnt - base !== 2) begin
            errors++;
            $display("FAIL stall_fires: got %0d, expected 2", fire_cnt - base);
        end
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h10 || bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: got if_valid %b pc %h req_valid %b, expected 1 10 0",
                     bus.if_valid, bus.if_pc, bus.imem_req_valid);
        end
        exp_q.push_back(64'h10);
        exp_q.push_back(64'h14);
        exp_q.push_back(64'h18);
        bus.if_ready = 1'b1;
        run_fires(1);
        drain("stall");
    endtask

    task automatic test_redirect();
        lat = 3;
        bus.if_ready = 1'b1;
        run_fires(2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h100;
        @(negedge clk);
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_blocks_req: got %b, expected 0", bus.imem_req_valid);
        end
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        exp_q.push_back(64'h100);
        exp_q.push_back(64'h104);
        @(negedge clk);
        checks++;
        if (bus.imem_req_addr !== 64'h100 || bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_addr: got addr %h valid %b, expected 100 0",
                     bus.imem_req_addr, bus.imem_req_valid);
        end
        run_fires(2);
        drain("redirect");
    endtask

    task automatic test_redirect_coincident();
        bit seen;
        lat = 1;
        bus.if_ready = 1'b0;
        exp_q.push_back(64'h108);
        run_fires(1);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            seen = bus.if_valid;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL coinc_fill: got if_valid 0, expected 1");
        end
        run_fires(1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h2F2;
        bus.if_ready       = 1'b1;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        exp_q.push_back(64'h2F0);
        exp_q.push_back(64'h2F4);
        @(negedge clk);
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h2F0 || bus.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL coinc_after: got req_valid %b addr %h if_valid %b, expected 1 2f0 0",
                     bus.imem_req_valid, bus.imem_req_addr, bus.if_valid);
        end
        @(posedge clk); #1;
        run_fires(2);
        drain("coinc");
    endtask

    task automatic test_req_stall();
        bus.imem_req_ready = 1'b0;
        bus.if_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h2F8 || bus.if_valid !== 1'b0) begin
                errors++;
                $display("FAIL req_stall: got valid %b addr %h if_valid %b, expected 1 2f8 0",
                         bus.imem_req_valid, bus.imem_req_addr, bus.if_valid);
            end
        end
        @(posedge clk); #1;
        exp_q.push_back(64'h2F8);
        run_fires(1);
        drain("req_stall");
    endtask

    task automatic test_reset_mid();
        lat = 1;
        bus.if_ready = 1'b0;
        run_fires(2);
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h2FC || bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_before_reset: got if_valid %b pc %h req_valid %b, expected 1 2fc 0",
                     bus.if_valid, bus.if_pc, bus.imem_req_valid);
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h0) begin
            errors++;
            $display("FAIL restart: got valid %b addr %h, expected 1 0", bus.imem_req_valid, bus.imem_req_addr);
        end
        @(posedge clk); #1;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h4);
        bus.if_ready = 1'b1;
        run_fires(2);
        drain("restart");
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h203;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h200) begin
            errors++;
            $display("FAIL redirect_align: got valid %b addr %h, expected 1 200", bus.imem_req_valid, bus.imem_req_addr);
        end
        @(posedge clk); #1;
        exp_q.push_back(64'h200);
        exp_q.push_back(64'h204);
        run_fires(2);
        drain("align");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        test_reset();
        test_stream();
        test_decode_stall();
        test_redirect();
        test_redirect_coincident();
        test_req_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
